msx_mouse_port: RTL and testbench
=================================

# msx_mouse_port

Parametrised MSX mouse encoder for the joystick ports, sitting between the PS/2 mouse controller and the `emsx_top` joystick inputs in the Neptuno top level. It replaces the single-port latch-and-overwrite mouse logic with the following:
- a signed, saturating delta accumulator, so no movement is lost between MSX reads;
- per-port strobe sequencers with timeout;
- selectable attachment of the mouse to any of `NUM_PORTS` ports;
- pass-through of the physical joystick on every port that is not in mouse mode.

## Interface
Parameters:
- `NUM_PORTS`, 2: number of MSX joystick ports.
- `TIMEOUT`, 100000: clk_sys cycles without a strobe edge before the sequencer returns to nibble 0.
- `DELTA_W`, 9: width of incoming two's-complement mouse deltas.
- `INVERT_X`, 1: 1 = negate X delta before accumulation (MSX convention).
- `INVERT_Y`, 0: 1 = negate Y delta before accumulation.

Ports:
- `clk_sys`, in, 1: system clock.
- `reset`, in, 1: reset, synchronous, active-high; clock clk_sys.
- `mouse_strobe`, in, 1: one-cycle pulse, new packet on `mouse_dx`/`mouse_dy`.
- `mouse_dx`, in, `DELTA_W`: signed X delta.
- `mouse_dy`, in, `DELTA_W`: signed Y delta.
- `mouse_btn`, in, 2: bit0 left, bit1 right, active-high.
- `port_sel`, in, `PSEL_W = max(1, clog2(NUM_PORTS))`: port the mouse is attached to.
- `joy_in`, in, `6*NUM_PORTS`: physical joysticks, active-low, 6 bits per port.
- `msx_str`, in, `NUM_PORTS`: pin-8 strobe per port, from the PSG.
- `port_out`, out, `6*NUM_PORTS`: value presented to the MSX, active-low buttons, registered.
- `mouse_active`, out, `NUM_PORTS`: port currently in mouse mode.

## Operation
- Accumulators `acc_x` and `acc_y` are 8-bit signed.
  - On `mouse_strobe`, `acc <= sat8(acc + (INV ? -d : d))`.
  - Computation uses `DELTA_W+2` bits.
  - `sat8` clamps the result to [-128, 127].
- Mouse-mode enable for port p:
  - Set when `mouse_strobe` fires and `port_sel == p`.
  - Cleared when `joy_in[p]` has any bit low (`~&joy_in[p]`).
  - Cleared on reset.
  - Cleared on any change of `port_sel`: all ports clear, and the sequencer returns to nibble 0.
  - Clear has priority over set in the same cycle.
- Per-port sequencer state is a 2-bit `nib` plus a timeout counter.
  - `str_d[p]` is the registered `msx_str[p]`.
  - An edge is `str_d ^ msx_str`, either polarity.
  - The sequencer is active only while in mouse mode.
  - On edge: `port_out[p][3:0]` gets the nibble for `nib`, `nib` increments (3 wraps to 0), and the timeout reloads to `TIMEOUT`.
  - Nibble map:
    - 0 → snap_x[7:4]
    - 1 → snap_x[3:0]
    - 2 → snap_y[7:4]
    - 3 → snap_y[3:0]
  - The bit0 of port_out = nibble LSB; the top level handles pin reordering.
- Snapshot:
  - On an edge with `nib == 0`, `snap_x/snap_y` take the current accumulators, and the accumulators are cleared in the same cycle.
  - The nibble output on that same edge uses the fresh accumulator value, not the old snap.
  - If `mouse_strobe` coincides with the snapshot, the accumulator becomes `sat8(0 + delta)`; the packet is not lost and is not included in the snapshot.
- Timeout:
  - When nonzero and no edge occurs, the counter decrements.
  - On the transition 1 → 0, `nib <= 0`.
  - Accumulators are untouched.
- `port_out[p][5:4]`:
  - In mouse mode, `~mouse_btn[1:0]`, registered every cycle.
  - Otherwise the whole `port_out[p] <= joy_in[p]` (pass-through).
- Only one port can be in mouse mode at a time.

## Timing
- Reset values:
  - `port_out` all ones.
  - `mouse_active` 0.
  - Accumulators, snaps, `nib`, timeouts and `str_d` 0.
- Latency:
  - Strobe edge to new nibble on `port_out`: 1 cycle, measured from the cycle `msx_str` changes.
  - Pass-through, button and `mouse_active` updates: 1 cycle.
- `msx_str` is synchronous to `clk_sys`; no synchroniser is used.
- A reset asserted mid-sequence returns everything to reset values on the next edge; a partially read packet is discarded.
- Two strobe edges on consecutive cycles are both honoured; one nibble is consumed per cycle.

## Test plan
- Mouse mode and full read: reset, `port_sel=0`, strobe dx=+5 dy=-3 (INVERT_X=1), then 4 `msx_str[0]` toggles.
  - Required nibbles: F, B, F, D (X = -5 = 0xFB, Y = 0xFD).
  - `mouse_active = 01`.
- Accumulation with saturation: strobe dx=-100 twice without a read; read X.
  - Required X = +127 (0x7F).
  - After a snapshot with no further packets, the next read yields 0, 0, 0, 0.
- Coincident packet and snapshot: strobe dx=-2 in the same cycle as the first edge.
  - The current packet returns the old accumulator.
  - The next packet returns X = 0x02.
- Timeout: two toggles, wait `TIMEOUT+2` cycles, toggle again.
  - Required nibble = X high nibble (`nib` reset to 0).
- Joystick override and port change: `joy_in[0]` bit2 low while in mouse mode.
  - Next cycle `mouse_active[0]=0` and `port_out[0]=joy_in[0]`.
  - Changing `port_sel` to 1 then strobing sets only `mouse_active[1]`.
- Buttons: `mouse_btn=2'b01` in mouse mode → `port_out[p][5:4]=2'b10` after 1 cycle; the non-mouse port is unaffected.

Source files
------------

// File: rtl/msx_mouse_port.sv
// MSX mouse encoder for the joystick ports: saturating delta accumulator,
// per-port nibble sequencers with timeout, and joystick pass-through.
module msx_mouse_port #(
  parameter int NUM_PORTS = 2,
  parameter int TIMEOUT   = 100000,
  parameter int DELTA_W   = 9,
  parameter bit INVERT_X  = 1'b1,
  parameter bit INVERT_Y  = 1'b0,
  localparam int PSEL_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     mouse_strobe,
  input  logic [DELTA_W-1:0]       mouse_dx,
  input  logic [DELTA_W-1:0]       mouse_dy,
  input  logic [1:0]               mouse_btn,
  input  logic [PSEL_W-1:0]        port_sel,
  input  logic [6*NUM_PORTS-1:0]   joy_in,
  input  logic [NUM_PORTS-1:0]     msx_str,
  output logic [6*NUM_PORTS-1:0]   port_out,
  output logic [NUM_PORTS-1:0]     mouse_active
);

  localparam int SUM_W = DELTA_W + 2;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic signed [SUM_W-1:0] MAXV = SUM_W'(127);
  localparam logic signed [SUM_W-1:0] MINV = -SUM_W'(128);

  function automatic logic signed [7:0] sat8(input logic signed [SUM_W-1:0] v);
    if (v > MAXV)      return 8'sd127;
    else if (v < MINV) return -8'sd128;
    else               return v[7:0];
  endfunction

  logic signed [7:0]       acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic signed [7:0]       snap_x_q, snap_x_d, snap_y_q, snap_y_d;
  logic [NUM_PORTS-1:0]    active_q, active_d, str_q, edge_w, seq_en;
  logic [1:0]              nib_q [NUM_PORTS];
  logic [1:0]              nib_d [NUM_PORTS];
  logic [TMO_W-1:0]        tmo_q [NUM_PORTS];
  logic [TMO_W-1:0]        tmo_d [NUM_PORTS];
  logic [5:0]              out_q [NUM_PORTS];
  logic [5:0]              out_d [NUM_PORTS];
  logic [PSEL_W-1:0]       sel_q;
  logic                    sel_chg, snap_fire;
  logic signed [SUM_W-1:0] dx_ext, dy_ext, dx_eff, dy_eff, base_x, base_y;
  logic [5:0]              joy;

  assign dx_ext = {{2{mouse_dx[DELTA_W-1]}}, mouse_dx};
  assign dy_ext = {{2{mouse_dy[DELTA_W-1]}}, mouse_dy};
  assign dx_eff = INVERT_X ? -dx_ext : dx_ext;
  assign dy_eff = INVERT_Y ? -dy_ext : dy_ext;

  // Mode control: clear (joystick activity or port change) beats set (packet).
  always_comb begin
    sel_chg   = (port_sel != sel_q);
    snap_fire = 1'b0;
    active_d  = active_q;
    edge_w    = str_q ^ msx_str;
    seq_en    = '0;
    joy       = '1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      joy = joy_in[6*p +: 6];
      if (sel_chg || !(&joy))
        active_d[p] = 1'b0;
      else if (mouse_strobe && (port_sel == PSEL_W'(p)))
        active_d[p] = 1'b1;
      seq_en[p] = active_q[p] & active_d[p];
      if (seq_en[p] && edge_w[p] && (nib_q[p] == 2'd0))
        snap_fire = 1'b1;
    end
  end

  // A packet coinciding with the snapshot lands on a cleared accumulator.
  always_comb begin
    base_x   = snap_fire ? '0 : {{(SUM_W-8){acc_x_q[7]}}, acc_x_q};
    base_y   = snap_fire ? '0 : {{(SUM_W-8){acc_y_q[7]}}, acc_y_q};
    acc_x_d  = base_x[7:0];
    acc_y_d  = base_y[7:0];
    if (mouse_strobe) begin
      acc_x_d = sat8(base_x + dx_eff);
      acc_y_d = sat8(base_y + dy_eff);
    end
    snap_x_d = snap_fire ? acc_x_q : snap_x_q;
    snap_y_d = snap_fire ? acc_y_q : snap_y_q;
  end

  // Per-port nibble sequencer and output register.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      nib_d[p] = nib_q[p];
      tmo_d[p] = tmo_q[p];
      out_d[p] = out_q[p];
      if (seq_en[p] && edge_w[p]) begin
        case (nib_q[p])
          2'd0:    out_d[p][3:0] = acc_x_q[7:4];
          2'd1:    out_d[p][3:0] = snap_x_q[3:0];
          2'd2:    out_d[p][3:0] = snap_y_q[7:4];
          default: out_d[p][3:0] = snap_y_q[3:0];
        endcase
        nib_d[p] = nib_q[p] + 2'd1;
        tmo_d[p] = TMO_W'(TIMEOUT);
      end else if (tmo_q[p] != '0) begin
        tmo_d[p] = tmo_q[p] - TMO_W'(1);
        if (tmo_q[p] == TMO_W'(1))
          nib_d[p] = 2'd0;
      end
      if (sel_chg)
        nib_d[p] = 2'd0;
      if (active_d[p])
        out_d[p][5:4] = ~mouse_btn;
      else
        out_d[p] = joy_in[6*p +: 6];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      snap_x_q <= '0;
      snap_y_q <= '0;
      active_q <= '0;
      str_q    <= '0;
      sel_q    <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        nib_q[p] <= '0;
        tmo_q[p] <= '0;
        out_q[p] <= '1;
      end
    end else begin
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      snap_x_q <= snap_x_d;
      snap_y_q <= snap_y_d;
      active_q <= active_d;
      str_q    <= msx_str;
      sel_q    <= port_sel;
      for (int p = 0; p < NUM_PORTS; p++) begin
        nib_q[p] <= nib_d[p];
        tmo_q[p] <= tmo_d[p];
        out_q[p] <= out_d[p];
      end
    end
  end

  always_comb begin
    port_out = '1;
    for (int p = 0; p < NUM_PORTS; p++)
      port_out[6*p +: 6] = out_q[p];
    mouse_active = active_q;
  end

endmodule

// File: tb/tb_msx_mouse_port.sv
// Directed bench for msx_mouse_port: mouse reads, saturation, snapshot
// coincidence, timeout, joystick override, port change and buttons.
module tb_msx_mouse_port;

  localparam int TMO = 20;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        mouse_strobe;
  logic [8:0]  mouse_dx, mouse_dy;
  logic [1:0]  mouse_btn;
  logic [0:0]  port_sel;
  logic [11:0] joy_in;
  logic [1:0]  msx_str;
  logic [11:0] port_out;
  logic [1:0]  mouse_active;

  int errors = 0;
  int checks = 0;

  msx_mouse_port #(.NUM_PORTS(2), .TIMEOUT(TMO), .DELTA_W(9),
                   .INVERT_X(1'b1), .INVERT_Y(1'b0)) dut (
    .clk_sys(clk_sys), .reset(reset), .mouse_strobe(mouse_strobe),
    .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .mouse_btn(mouse_btn),
    .port_sel(port_sel), .joy_in(joy_in), .msx_str(msx_str),
    .port_out(port_out), .mouse_active(mouse_active)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pkt(input int dx, input int dy);
    logic [31:0] vx, vy;
    vx = dx;
    vy = dy;
    mouse_dx = vx[8:0];
    mouse_dy = vy[8:0];
    mouse_strobe = 1'b1;
    tick();
    mouse_strobe = 1'b0;
    mouse_dx = '0;
    mouse_dy = '0;
  endtask

  task automatic rd(input int p, input logic [3:0] exp, input string tag);
    msx_str[p] = ~msx_str[p];
    tick();
    chk(tag, 32'(port_out[6*p +: 4]), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; mouse_strobe = 1'b0; mouse_dx = '0; mouse_dy = '0;
    mouse_btn = 2'b00; port_sel = 1'b0; joy_in = '1; msx_str = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_port_out", 32'(port_out), 32'hFFF);
    chk("rst_active", 32'(mouse_active), 32'h0);

    // Mouse on port 0, joystick pattern on port 1
    joy_in[11:6] = 6'b010101;
    pkt(5, -3);
    chk("mm_active", 32'(mouse_active), 32'h1);
    chk("mm_passthru1", 32'(port_out[11:6]), 32'h15);
    chk("mm_btn_idle", 32'(port_out[5:4]), 32'h3);
    rd(0, 4'hF, "rd1_n0"); rd(0, 4'hB, "rd1_n1");
    rd(0, 4'hF, "rd1_n2"); rd(0, 4'hD, "rd1_n3");

    // Saturation: +100 +100 clamps to +127
    pkt(-100, 0); pkt(-100, 0);
    rd(0, 4'h7, "sat_n0"); rd(0, 4'hF, "sat_n1");
    rd(0, 4'h0, "sat_n2"); rd(0, 4'h0, "sat_n3");
    rd(0, 4'h0, "empty_n0"); rd(0, 4'h0, "empty_n1");
    rd(0, 4'h0, "empty_n2"); rd(0, 4'h0, "empty_n3");

    // Packet coinciding with the snapshot edge
    pkt(3, 1);
    mouse_dx = 9'h1FE; mouse_dy = '0; mouse_strobe = 1'b1;
    rd(0, 4'hF, "coin_n0");
    mouse_strobe = 1'b0; mouse_dx = '0;
    rd(0, 4'hD, "coin_n1"); rd(0, 4'h0, "coin_n2"); rd(0, 4'h1, "coin_n3");
    rd(0, 4'h0, "next_n0"); rd(0, 4'h2, "next_n1");
    rd(0, 4'h0, "next_n2"); rd(0, 4'h0, "next_n3");

    // Timeout returns the sequencer to nibble 0
    pkt(-16, 0);
    rd(0, 4'h1, "tmo_n0"); rd(0, 4'h0, "tmo_n1");
    pkt(-48, 0);
    repeat (TMO + 1) tick();
    rd(0, 4'h3, "tmo_after_n0"); rd(0, 4'h0, "tmo_after_n1");
    rd(0, 4'h0, "tmo_after_n2"); rd(0, 4'h0, "tmo_after_n3");

    // Joystick activity overrides mouse mode
    joy_in[5:0] = 6'b111011;
    tick();
    chk("ovr_active", 32'(mouse_active), 32'h0);
    chk("ovr_passthru0", 32'(port_out[5:0]), 32'h3B);
    joy_in[5:0] = 6'b111111;
    tick();
    chk("ovr_release", 32'(port_out[5:0]), 32'h3F);

    // Port change then attach to port 1
    joy_in[11:6] = 6'b111111;
    port_sel = 1'b1;
    tick();
    joy_in[5:0] = 6'b101010;
    pkt(0, 0);
    chk("sel1_active", 32'(mouse_active), 32'h2);

    // Buttons on the mouse port, other port untouched
    mouse_btn = 2'b01;
    tick();
    chk("btn_bits", 32'(port_out[11:10]), 32'h2);
    chk("btn_other", 32'(port_out[5:0]), 32'h2A);
    chk("btn_active", 32'(mouse_active), 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
